// File: rtl/dmem_arbiter.sv
// Round-robin two-port front end for a byte-wide registered data memory (optional DMEM_ARBITER_ALIGN_CHK_EN).
// Latency: write 2 cycles, byte read 3, word read 4, misaligned word (when checked) 1; accept to rvalid.
// Backpressure: pN_ready is offered only in IDLE to the arbitration winner; a request holds until accepted.
module dmem_arbiter #(
  parameter int ADDR_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                p0_valid,
  output logic                p0_ready,
  input  logic                p0_we,
  input  logic                p0_size,
  input  logic [ADDR_LEN-1:0] p0_addr,
  input  logic [15:0]         p0_wdata,
  output logic                p0_rvalid,
  input  logic                p1_valid,
  output logic                p1_ready,
  input  logic                p1_we,
  input  logic                p1_size,
  input  logic [ADDR_LEN-1:0] p1_addr,
  input  logic [15:0]         p1_wdata,
  output logic                p1_rvalid,
  output logic [15:0]         rdata,
  output logic                resp_err,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [15:0]         mem_in,
  output logic                mem_mov_sz,
  output logic                mem_we,
  input  logic [15:0]         mem_out
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    ADDR_HI,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

  typedef struct packed {
    logic                port;
    logic                we;
    logic                size;
    logic [ADDR_LEN-1:0] addr;
    logic [15:0]         wdata;
  } req_t;

  state_t state;
  req_t   req;
  req_t   sel_req;
  logic   last_grant;
  logic   grant_port;
  logic   any_valid;
  logic   accept;
  logic   misaligned;
  logic [7:0] lo;
  logic   mem_out_unused;

  // The memory is byte wide; the upper half of its read port carries nothing useful.
  assign mem_out_unused = ^mem_out[15:8];

  assign any_valid  = p0_valid | p1_valid;
  assign grant_port = (p0_valid && p1_valid) ? ~last_grant : ~p0_valid;
  assign accept     = (state == IDLE) && any_valid;
  assign p0_ready   = accept && !grant_port;
  assign p1_ready   = accept && grant_port;

  always_comb begin
    sel_req      = '0;
    sel_req.port = grant_port;
    if (grant_port) begin
      sel_req.we    = p1_we;
      sel_req.size  = p1_size;
      sel_req.addr  = p1_addr;
      sel_req.wdata = p1_wdata;
    end else begin
      sel_req.we    = p0_we;
      sel_req.size  = p0_size;
      sel_req.addr  = p0_addr;
      sel_req.wdata = p0_wdata;
    end
  end

`ifdef DMEM_ARBITER_ALIGN_CHK_EN
  logic err_q;
  assign misaligned = sel_req.size & sel_req.addr[0];
  assign resp_err   = (state == RESP) && err_q;
`else
  assign misaligned = 1'b0;
  assign resp_err   = 1'b0;
`endif

  // Memory-side outputs come straight from the latched request; only ADDR_HI offsets the address.
  assign mem_addr   = req.addr + {{(ADDR_LEN-1){1'b0}}, (state == ADDR_HI)};
  assign mem_in     = req.wdata;
  assign mem_mov_sz = req.size;
  assign mem_we     = (state == WRITE);
  assign p0_rvalid  = (state == RESP) && !req.port;
  assign p1_rvalid  = (state == RESP) && req.port;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req        <= '0;
      last_grant <= 1'b1;
      lo         <= 8'h00;
      rdata      <= 16'h0000;
`ifdef DMEM_ARBITER_ALIGN_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req        <= sel_req;
            last_grant <= grant_port;
`ifdef DMEM_ARBITER_ALIGN_CHK_EN
            err_q      <= misaligned;
`endif
            if (misaligned) begin
              rdata <= 16'h0000;
              state <= RESP;
            end else if (sel_req.we) begin
              state <= WRITE;
            end else begin
              state <= ADDR_LO;
            end
          end
        end
        ADDR_LO: state <= req.size ? ADDR_HI : CAPTURE;
        ADDR_HI: begin
          lo    <= mem_out[7:0];
          state <= CAPTURE;
        end
        // Read data is assembled here so rdata is stable for the whole RESP cycle.
        CAPTURE: begin
          rdata <= req.size ? {mem_out[7:0], lo} : {8'h00, mem_out[7:0]};
          state <= RESP;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_valid = 1'b0, p0_we = 1'b0, p0_size = 1'b0;
  logic [15:0] p0_addr = '0, p0_wdata = '0;
  logic        p1_valid = 1'b0, p1_we = 1'b0, p1_size = 1'b0;
  logic [15:0] p1_addr = '0, p1_wdata = '0;
  logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [15:0] rdata;
  logic        resp_err;
  logic [15:0] mem_addr, mem_in;
  logic        mem_mov_sz, mem_we;
  logic [15:0] mem_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  mem [0:65535];
  bit          wr_mask [0:65535];
  logic [15:0] last_rdata = 16'h0000;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_size(p0_size),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_size(p1_size),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_mov_sz(mem_mov_sz), .mem_we(mem_we),
    .mem_out(mem_out)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 7) ^ 90);
  endfunction

  function automatic logic [7:0] dev_byte(input logic [15:0] a);
    return wr_mask[a] ? mem[a] : init_byte(int'(a));
  endfunction

  // Byte-wide memory device with a registered read port and a two-byte write mode.
  always @(posedge clk) begin
    logic [15:0] a1;
    a1 = mem_addr + 16'd1;
    if (mem_we) begin
      mem[mem_addr]     <= mem_in[7:0];
      wr_mask[mem_addr] <= 1'b1;
      if (mem_mov_sz) begin
        mem[a1]     <= mem_in[15:8];
        wr_mask[a1] <= 1'b1;
      end
    end
    mem_out <= {8'($urandom), dev_byte(mem_addr)};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a, input bit sz);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return sz ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  function automatic logic rdy(input int port);
    return (port == 1) ? p1_ready : p0_ready;
  endfunction

  function automatic logic rv(input int port);
    return (port == 1) ? p1_rvalid : p0_rvalid;
  endfunction

  task automatic drive(input int port, input bit v, input bit we, input bit sz,
                       input logic [15:0] a, input logic [15:0] wd);
    if (port == 1) begin
      p1_valid = v; p1_we = we; p1_size = sz; p1_addr = a; p1_wdata = wd;
    end else begin
      p0_valid = v; p0_we = we; p0_size = sz; p0_addr = a; p0_wdata = wd;
    end
  endtask

  task automatic do_req(input int port, input bit we, input bit sz,
                        input logic [15:0] a, input logic [15:0] wd);
    bit          got, misal, other;
    int          lat, rv_cyc, we_cnt, we_cyc;
    logic [15:0] exp_rdata, addr_c1, addr_c2, we_addr, we_in, got_rdata, a1;
    logic        we_sz, got_err;
    misal = 1'b0;
`ifdef DMEM_ARBITER_ALIGN_CHK_EN
    misal = sz && a[0];
`endif
    lat = misal ? 1 : (we ? 2 : (sz ? 4 : 3));
    exp_rdata = misal ? 16'h0000 : (we ? last_rdata : ref_read(a, sz));
    a1 = a + 16'd1;

    @(negedge clk);
    drive(port, 1'b1, we, sz, a, wd);
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      #1;
      if (rdy(port)) got = 1'b1;
      else @(negedge clk);
    end
    check("accept", 32'(got), 32'd1);
    if (!got) begin
      drive(port, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      return;
    end
    @(posedge clk);
    #1;
    drive(port, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));

    if (!misal && we) begin
      ref_mem[a] = wd[7:0];
      if (sz) ref_mem[a1] = wd[15:8];
    end
    last_rdata = exp_rdata;

    rv_cyc = 0; we_cnt = 0; we_cyc = 0; other = 1'b0;
    addr_c1 = '0; addr_c2 = '0; we_addr = '0; we_in = '0; we_sz = 1'b0;
    got_rdata = '0; got_err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) addr_c1 = mem_addr;
      if (c == 2) addr_c2 = mem_addr;
      if (mem_we) begin
        we_cnt++; we_cyc = c; we_addr = mem_addr; we_in = mem_in; we_sz = mem_mov_sz;
      end
      if (rv(1 - port)) other = 1'b1;
      if (rv(port)) begin
        rv_cyc = c; got_rdata = rdata; got_err = resp_err;
        break;
      end
    end
    check("latency", 32'(rv_cyc), 32'(lat));
    check("other_rvalid", 32'(other), 32'd0);
    check("rdata", 32'(got_rdata), 32'(exp_rdata));
    check("resp_err", 32'(got_err), 32'(misal));
    check("we_count", 32'(we_cnt), (we && !misal) ? 32'd1 : 32'd0);
    if (we && !misal) begin
      check("we_cycle", 32'(we_cyc), 32'd1);
      check("we_addr", 32'(we_addr), 32'(a));
      check("we_data", 32'(we_in), 32'(wd));
      check("we_size", 32'(we_sz), 32'(sz));
    end
    if (!we && !misal) begin
      check("rd_addr_lo", 32'(addr_c1), 32'(a));
      if (sz) check("rd_addr_hi", 32'(addr_c2), 32'(a1));
    end
  endtask

  task automatic reset_midop();
    bit seen;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b1, 16'h0300, 16'h0);
    #1;
    check("rst_accept", 32'(p0_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_addr_hi", 32'(mem_addr), 32'h0301);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    last_rdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (p0_rvalid || p1_rvalid) seen = 1'b1;
    end
    check("rst_no_stale", 32'(seen), 32'd0);
  endtask

  initial begin
    int acc_port[$], acc_t[$], rv_port[$], rv_t[$];
    logic [15:0] rv_dat[$];
    int both;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

    // Reset state, with both ports already contending.
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0);
    repeat (3) @(negedge clk);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_err", 32'(resp_err), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_in", 32'(mem_in), 32'd0);
    check("reset_mov_sz", 32'(mem_mov_sz), 32'd0);
    check("reset_ready", 32'({p1_ready, p0_ready}), 32'd1);
    rst_n = 1'b1;

    both = 0;
    for (int t = 0; t < 18; t++) begin
      #1;
      if (p0_ready && p1_ready) both++;
      if (p0_ready) begin acc_port.push_back(0); acc_t.push_back(t); end
      else if (p1_ready) begin acc_port.push_back(1); acc_t.push_back(t); end
      if (p0_rvalid) begin rv_port.push_back(0); rv_t.push_back(t); rv_dat.push_back(rdata); end
      if (p1_rvalid) begin rv_port.push_back(1); rv_t.push_back(t); rv_dat.push_back(rdata); end
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (4) @(negedge clk);
    check("cont_both_ready", 32'(both), 32'd0);
    check("cont_n_acc", 32'(acc_port.size() >= 4), 32'd1);
    check("cont_n_rv", 32'(rv_port.size() >= 4), 32'd1);
    if (acc_port.size() >= 4 && rv_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("cont_grant", 32'(acc_port[i]), 32'(i % 2));
        check("cont_spacing", 32'(acc_t[i] - acc_t[0]), 32'(4 * i));
        check("cont_rv_port", 32'(rv_port[i]), 32'(acc_port[i]));
        check("cont_rv_time", 32'(rv_t[i]), 32'(acc_t[i] + 3));
        check("cont_rdata", 32'(rv_dat[i]),
              32'(ref_read((acc_port[i] == 0) ? 16'h0100 : 16'h0200, 1'b0)));
      end
    end
    last_rdata = ref_read(16'h0100, 1'b0);

    // Directed sequences.
    do_req(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'h0000);
    check("word_rd_beef", 32'(last_rdata), 32'h0000BEEF);
    do_req(1, 1'b0, 1'b0, 16'h0011, 16'h0000);
    check("byte_rd_be", 32'(last_rdata), 32'h000000BE);
    do_req(1, 1'b1, 1'b1, 16'hFFFF, 16'h1234);
    do_req(0, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    check("wrap_rd", 32'(last_rdata), 32'h00001234);
    do_req(0, 1'b0, 1'b1, 16'h0021, 16'h0000);
    do_req(1, 1'b1, 1'b1, 16'h0023, 16'hA5C3);
    do_req(1, 1'b0, 1'b1, 16'h0022, 16'h0000);

    reset_midop();
    do_req(0, 1'b0, 1'b1, 16'h0300, 16'h0000);

    // Random traffic with address hot spots near the wrap point and odd addresses.
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF;
        1: a = 16'hFFF0 + 16'($urandom_range(0, 15));
        2: a = 16'h0040 + 16'($urandom_range(0, 31));
        default: a = 16'($urandom);
      endcase
      do_req(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), a, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
